// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store traffic:
// data wins by default, a starvation counter forces fetch through, and a timeout aborts hung accesses.
module unified_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ready,
   output logic                i_err,
   input  logic                d_req,
   input  logic                d_wen,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ready,
   output logic                d_err,
   output logic                mem_req,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready
);
   localparam int BE_W = DATA_W / 8;
   localparam int SC_W = $clog2(STARVE_MAX + 1);
   localparam int TC_W = $clog2(TIMEOUT + 1);
   localparam logic [SC_W-1:0] STARVE_LIM  = SC_W'(STARVE_MAX);
   localparam logic [TC_W-1:0] TIMEOUT_LIM = TC_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;

   state_e              state_q, state_d;
   logic [SC_W-1:0]     starve_q, starve_d;
   logic [TC_W-1:0]     tmo_q, tmo_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]     mem_be_q, mem_be_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic                i_ready_q, i_ready_d;
   logic                i_err_q, i_err_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                d_ready_q, d_ready_d;
   logic                d_err_q, d_err_d;

   logic i_eff, d_eff, grant_i, grant_d, timed_out;

   // A requester is deaf in its own completion cycle; a held request counts again one cycle later.
   assign i_eff     = i_req & ~i_ready_q;
   assign d_eff     = d_req & ~d_ready_q;
   assign grant_i   = i_eff & (~d_eff | (starve_q == STARVE_LIM));
   assign grant_d   = d_eff & ~grant_i;
   assign timed_out = ~mem_ready & ((tmo_q + TC_W'(1)) == TIMEOUT_LIM);

   always_comb begin
      // NOTE: every next-state value defaults to its current value (pulses to 0) first, so no path leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      mem_req_d   = mem_req_q;
      mem_wen_d   = mem_wen_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      i_rdata_d   = i_rdata_q;
      i_ready_d   = 1'b0;
      i_err_d     = 1'b0;
      d_rdata_d   = d_rdata_q;
      d_ready_d   = 1'b0;
      d_err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d     = DBUSY;
               mem_req_d   = 1'b1;
               mem_wen_d   = d_wen;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
               tmo_d       = '0;
               if (!i_req)
                  starve_d = '0;
               else if (starve_q != STARVE_LIM)
                  starve_d = starve_q + SC_W'(1);
            end else if (grant_i) begin
               state_d     = IBUSY;
               mem_req_d   = 1'b1;
               mem_wen_d   = 1'b0;
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
               mem_be_d    = '1;
               tmo_d       = '0;
               starve_d    = '0;
            end
         end
         IBUSY, DBUSY: begin
            if (mem_ready || timed_out) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == IBUSY) begin
                  i_ready_d = 1'b1;
                  i_err_d   = ~mem_ready;
                  if (mem_ready)
                     i_rdata_d = mem_rdata;
               end else begin
                  d_ready_d = 1'b1;
                  d_err_d   = ~mem_ready;
                  if (mem_ready && !mem_wen_q)
                     d_rdata_d = mem_rdata;
               end
            end else begin
               tmo_d = tmo_q + TC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         i_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         i_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         d_ready_q   <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         i_rdata_q   <= i_rdata_d;
         i_ready_q   <= i_ready_d;
         i_err_q     <= i_err_d;
         d_rdata_q   <= d_rdata_d;
         d_ready_q   <= d_ready_d;
         d_err_q     <= d_err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign i_rdata   = i_rdata_q;
   assign i_ready   = i_ready_q;
   assign i_err     = i_err_q;
   assign d_rdata   = d_rdata_q;
   assign d_ready   = d_ready_q;
   assign d_err     = d_err_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: requester agents, a memory responder with
// hang regions, and a cycle-level reference of the arbitration rules.
module tb_unified_mem_arbiter;
   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 16;
   localparam int N_TXN      = 120;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_ready, i_err;
   logic        d_req = 1'b0, d_wen = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_rdata;
   logic        d_ready, d_err;
   logic        mem_req, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   unified_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .n_rst(n_rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
   endfunction

   // Memory responder: addresses with [15:12]==F never answer, others answer after 0..3 wait cycles.
   logic [31:0] resp_mem [logic [31:0]];
   int          resp_force = -1;

   function automatic logic [31:0] resp_rd(input logic [31:0] a);
      if (resp_mem.exists(a)) return resp_mem[a];
      return init_word(a);
   endfunction

   initial begin : responder
      bit          active, hang;
      int          wait_cnt, hi;
      logic [31:0] w;
      active = 0; hang = 0; wait_cnt = 0; hi = 0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            mem_ready = 1'b0;
            active    = 0;
         end else if (mem_req) begin
            if (!active) begin
               active   = 1;
               hang     = (mem_addr[15:12] == 4'hF);
               hi       = 0;
               wait_cnt = (resp_force >= 0) ? resp_force : int'($urandom_range(0, 3));
            end
            hi++;
            if (!hang && wait_cnt == 0) begin
               mem_ready = 1'b1;
               mem_rdata = resp_rd(mem_addr);
               if (mem_wen) begin
                  w = mem_rdata;
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                  resp_mem[mem_addr] = w;
               end
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
               if (wait_cnt > 0) wait_cnt--;
            end
         end else begin
            if (active && hang) check("timeout_len", 32'(hi), 32'(TIMEOUT));
            active    = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
      end
   end

   // Reference: one outstanding access, requester masked in its completion cycle,
   // data preferred unless fetch has lost STARVE_MAX times, abort after TIMEOUT busy cycles.
   bit          m_busy = 0, m_own_d = 0, m_done_i = 0, m_done_d = 0, m_err = 0;
   bit          m_prev_i, m_prev_d, m_ie, m_de;
   int          m_starve = 0, m_timer = 0;
   logic [31:0] m_addr = '0, m_wdata = '0;
   logic        m_wen = 1'b0;
   logic [3:0]  m_be = '0;

   initial forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
         m_busy = 0; m_done_i = 0; m_done_d = 0; m_err = 0; m_starve = 0; m_timer = 0;
      end else begin
         m_prev_i = m_done_i; m_prev_d = m_done_d;
         m_done_i = 0; m_done_d = 0; m_err = 0;
         if (!m_busy) begin
            m_ie = i_req && !m_prev_i;
            m_de = d_req && !m_prev_d;
            if (m_ie && (!m_de || m_starve == STARVE_MAX)) begin
               m_busy = 1; m_own_d = 0; m_timer = 0; m_starve = 0;
               m_addr = i_addr; m_wen = 1'b0; m_wdata = '0; m_be = 4'hF;
            end else if (m_de) begin
               m_busy = 1; m_own_d = 1; m_timer = 0;
               m_starve = i_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
               m_addr = d_addr; m_wen = d_wen; m_wdata = d_wdata; m_be = d_be;
            end
         end else begin
            m_timer++;
            if (mem_ready || m_timer == TIMEOUT) begin
               m_busy = 0;
               m_err  = !mem_ready;
               if (m_own_d) m_done_d = 1; else m_done_i = 1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (n_rst) begin
         check("mem_req", 32'(mem_req), 32'(m_busy));
         check("i_ready", 32'(i_ready), 32'(m_done_i));
         check("d_ready", 32'(d_ready), 32'(m_done_d));
         if (m_done_i) check("i_err", 32'(i_err), 32'(m_err));
         if (m_done_d) check("d_err", 32'(d_err), 32'(m_err));
         if (m_busy) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wen", 32'(mem_wen), 32'(m_wen));
            check("mem_wdata", mem_wdata, m_wdata);
            check("mem_be", 32'(mem_be), 32'(m_be));
         end
      end
   end

   logic [31:0] i_last = '0, d_last = '0;
   logic [31:0] dref [8];

   task automatic wait_rdy(input bit is_d, output int lat);
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if ((is_d ? d_ready : i_ready) == 1'b1) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) check(is_d ? "d_ready_timeout" : "i_ready_timeout",
                         32'(is_d ? d_ready : i_ready), 32'd1);
   endtask

   task automatic fetch_agent();
      int lat, gap, k;
      bit hang;
      logic [31:0] a, exp;
      for (int n = 0; n < N_TXN; n++) begin
         hang = ($urandom_range(0, 9) == 0);
         k    = int'($urandom_range(0, 15));
         a    = (hang ? 32'hF000 : 32'h1000) + 32'(4 * k);
         i_req = 1'b1; i_addr = a;
         wait_rdy(1'b0, lat);
         exp = hang ? i_last : init_word(a);
         check("i_err_rnd", 32'(i_err), 32'(hang));
         check("i_rdata_rnd", i_rdata, exp);
         i_last = exp;
         gap = int'($urandom_range(0, 2));
         if (gap > 0) begin
            i_req = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      i_req = 1'b0;
   endtask

   task automatic data_agent();
      int lat, gap, k;
      bit hang, wen;
      logic [31:0] a, exp, wd;
      logic [3:0] be;
      for (int n = 0; n < N_TXN; n++) begin
         hang = ($urandom_range(0, 11) == 0);
         k    = int'($urandom_range(0, 7));
         a    = (hang ? 32'hF100 : 32'h2000) + 32'(4 * k);
         wen  = 1'($urandom_range(0, 1));
         wd   = $urandom;
         be   = 4'($urandom_range(0, 15));
         d_req = 1'b1; d_wen = wen; d_addr = a; d_wdata = wd; d_be = be;
         wait_rdy(1'b1, lat);
         exp = (!hang && !wen) ? dref[k] : d_last;
         check("d_err_rnd", 32'(d_err), 32'(hang));
         check("d_rdata_rnd", d_rdata, exp);
         d_last = exp;
         if (!hang && wen)
            for (int b = 0; b < 4; b++)
               if (be[b]) dref[k][8*b +: 8] = wd[8*b +: 8];
         gap = int'($urandom_range(0, 2));
         if (gap > 0) begin
            d_req = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      d_req = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      for (int k = 0; k < 8; k++) dref[k] = init_word(32'h2000 + 32'(4 * k));

      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_i_ready", 32'(i_ready), 32'd0);
      check("rst_d_ready", 32'(d_ready), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      n_rst = 1'b1;
      @(negedge clk);

      // single fetch, memory answers at once
      resp_force = 0;
      resp_mem[32'h4] = 32'h00A00093;
      i_req = 1'b1; i_addr = 32'h4;
      @(negedge clk);
      check("sf_mem_addr", mem_addr, 32'h4);
      check("sf_mem_be", 32'(mem_be), 32'hF);
      check("sf_mem_wen", 32'(mem_wen), 32'd0);
      check("sf_early", 32'(i_ready), 32'd0);
      @(negedge clk);
      check("sf_ready_lat2", 32'(i_ready), 32'd1);
      check("sf_rdata", i_rdata, 32'h00A00093);
      check("sf_err", 32'(i_err), 32'd0);
      i_req = 1'b0; i_last = 32'h00A00093;
      @(negedge clk);

      // store then back-to-back load of the same word
      d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0; d_wdata = 32'd100; d_be = 4'hF;
      @(negedge clk);
      check("st_mem_wen", 32'(mem_wen), 32'd1);
      wait_rdy(1'b1, lat);
      check("st_rdata_held", d_rdata, 32'd0);
      check("st_err", 32'(d_err), 32'd0);
      d_wen = 1'b0;
      @(negedge clk);
      check("ld_masked", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("ld_mem_wen", 32'(mem_wen), 32'd0);
      wait_rdy(1'b1, lat);
      check("ld_rdata", d_rdata, 32'd100);
      d_req = 1'b0; d_last = 32'd100;
      @(negedge clk);

      // simultaneous requests: data first, fetch granted in the d_ready cycle
      i_req = 1'b1; i_addr = 32'h1000;
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h2000;
      @(negedge clk);
      check("sim_data_first", mem_addr, 32'h2000);
      @(negedge clk);
      check("sim_d_ready", 32'(d_ready), 32'd1);
      check("sim_d_rdata", d_rdata, dref[0]);
      d_req = 1'b0; d_last = dref[0];
      @(negedge clk);
      check("sim_fetch_next", mem_addr, 32'h1000);
      check("sim_one_ready", 32'(i_ready | d_ready), 32'd0);
      @(negedge clk);
      check("sim_i_ready", 32'(i_ready), 32'd1);
      check("sim_i_rdata", i_rdata, init_word(32'h1000));
      i_req = 1'b0; i_last = init_word(32'h1000);
      @(negedge clk);

      // timeout, then a normal fetch
      i_req = 1'b1; i_addr = 32'hF000;
      wait_rdy(1'b0, lat);
      check("to_latency", 32'(lat), 32'(TIMEOUT + 1));
      check("to_err", 32'(i_err), 32'd1);
      check("to_rdata_held", i_rdata, i_last);
      i_addr = 32'h1004;
      wait_rdy(1'b0, lat);
      check("after_to_err", 32'(i_err), 32'd0);
      check("after_to_rdata", i_rdata, init_word(32'h1004));
      i_req = 1'b0; i_last = init_word(32'h1004);
      @(negedge clk);

      resp_force = -1;
      fork
         fetch_agent();
         data_agent();
      join
      repeat (3) @(negedge clk);

      // asynchronous reset in the middle of a data access
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'hF200;
      repeat (4) @(negedge clk);
      check("rst_pre_busy", 32'(mem_req), 32'd1);
      #2 n_rst = 1'b0;
      #1;
      check("arst_mem_req", 32'(mem_req), 32'd0);
      check("arst_mem_addr", mem_addr, 32'd0);
      check("arst_d_ready", 32'(d_ready), 32'd0);
      check("arst_d_rdata", d_rdata, 32'd0);
      check("arst_i_rdata", i_rdata, 32'd0);
      d_req = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("arst_no_ready", 32'(d_ready), 32'd0);
      end
      resp_force = 0;
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h2004;
      @(negedge clk);
      check("post_rst_grant", mem_addr, 32'h2004);
      @(negedge clk);
      check("post_rst_ready", 32'(d_ready), 32'd1);
      check("post_rst_rdata", d_rdata, dref[1]);
      d_req = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates one single-port unified memory between the core's instruction-fetch path and its load/store path.
- Sits between the fetch stage, the LSU and the shared memory, so the core can run a von-Neumann memory map instead of separate instruction and data arrays.
- Data requests normally have priority. A starvation counter guarantees fetch forward progress.
- A per-transaction timeout reports a hung memory as an error completion instead of deadlocking the core.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch request is pending before fetch is forced.
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ready before the transaction is aborted.

Ports:
- clk  in  1  core clock
- n_rst  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched instruction, valid when i_ready=1
- i_ready  out  1  one-cycle fetch completion pulse
- i_err  out  1  fetch timed out; valid with i_ready
- d_req  in  1  load/store request; held with d_wen, d_addr, d_wdata, d_be stable until d_ready
- d_wen  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid when d_ready=1 and d_wen was 0
- d_ready  out  1  one-cycle data completion pulse
- d_err  out  1  data access timed out; valid with d_ready
- mem_req  out  1  memory access strobe; held until mem_ready
- mem_wen  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables (all ones for fetch)
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, sampled only while mem_req=1

Behaviour:
- Reset: every output is 0, state is IDLE, starvation and timeout counters are 0. Reset asserted mid-transaction drops the transaction silently; no ready pulse is produced.
- States: IDLE, IBUSY, DBUSY. All outputs are registered.
- IDLE arbitration at each posedge:
  - d_req only: go to DBUSY.
  - i_req only: go to IBUSY.
  - Both requests: DBUSY, unless starve_cnt==STARVE_MAX, in which case IBUSY.
  - Neither request: stay in IDLE.
- Grant capture: on entry to xBUSY, the arbiter latches the requester's address, wen, wdata and be into the mem_* registers and sets mem_req=1. A fetch drives mem_wen=0, mem_be=all ones and mem_wdata=0.
- starve_cnt:
  - +1 on each DBUSY grant while i_req=1, saturating at STARVE_MAX.
  - Cleared on any IBUSY grant.
  - Cleared on a DBUSY grant taken while i_req=0.
- xBUSY, mem_ready=1:
  - Set mem_req=0.
  - Capture mem_rdata into x_rdata (loads and fetches only; d_rdata holds its previous value on a store).
  - Pulse x_ready=1 for exactly one cycle, with x_err=0.
  - Return to IDLE.
- xBUSY, no mem_ready: the timeout counter increments each cycle. When it reaches TIMEOUT, the arbiter drops mem_req, pulses x_ready=1 with x_err=1 and x_rdata unchanged, and returns to IDLE. The counter clears on every grant.
- Latency: request sampled at edge N gives mem_req high after N. mem_ready sampled at edge M gives x_ready high in cycle M+1. Minimum request-to-ready is 2 cycles.
- Completion handshake: in the cycle x_ready=1 (the arbiter is already in IDLE), that requester's x_req is ignored for arbitration. A still-high x_req is treated as a new request from the following cycle. The other requester may be granted in that same cycle.
- i_ready and d_ready are never both high in one cycle. At most one memory transaction is outstanding.
- Changes to a requester's inputs while its transaction is in xBUSY have no effect, because the fields are latched at grant.

Test Plan:
- Single fetch: i_req, i_addr=0x04, mem_ready one cycle after mem_req, mem_rdata=0x00A00093 -> mem_addr=0x04, mem_be=0xF, mem_wen=0; i_ready pulse with i_rdata=0x00A00093 two cycles after i_req; i_err=0.
- Store then load: d_req store d_addr=0x0, d_wdata=100, d_be=0xF, then load d_addr=0x0 with memory returning 100 -> mem_wen=1 then 0; d_rdata=100 on the second d_ready; d_rdata unchanged on the first.
- Simultaneous requests: i_req and d_req both asserted in IDLE -> data granted first; fetch granted immediately after d_ready; exactly one ready pulse per cycle.
- Starvation: d_req held continuously with back-to-back new loads, i_req held, STARVE_MAX=4 -> 4 data grants, then a fetch grant; starve_cnt returns to 0.
- Timeout: i_req with mem_ready held at 0, TIMEOUT=16 -> mem_req high for 16 cycles, then i_ready=1 and i_err=1, state IDLE; a following request completes normally.
- Reset mid-operation: n_rst pulled low asynchronously while in DBUSY -> all outputs 0 immediately, no d_ready after release, and the next d_req is granted from IDLE.
